wb_spi_ctrl_regs: RTL and testbench

Parametrised Wishbone B4 slave register block that controls one SPI master engine serving up to `NUM_CS` chip selects. It replaces the fixed 32-bit, 2-select SPI control slave. New features are a configurable data width, a busy/done/overrun status register with write-1-to-clear bits, an interrupt output, and a self-clearing start pulse. It sits between the PCI-to-Wishbone bridge and the SPI shift engine.

---
 rtl/wb_spi_ctrl_regs.sv | 229 ++++++++++++++++++++++
 tb/tb_wb_spi_ctrl_regs.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_spi_ctrl_regs.sv
// -----------------------------------------------------------------------------
// wb_spi_ctrl_regs
//
// Wishbone B4 slave register block that controls one SPI master engine.
// It sits between the PCI-to-Wishbone bridge and the SPI shift engine.
//
// Register map (word address = adr_i[ADR_BITS+1:2]):
//   0 TXDATA  R/W   TX word, byte-lane writes
//   1 RXDATA  RO    captured from spi_dat_i on every spi_done_i
//   2 CTRL    R/W   [0] START (write-only, reads 0), [1] IRQ_EN, [8+:CSW] CS
//   3 STATUS        [0] BUSY (RO), [1] DONE (W1C), [2] OVR (W1C)
//   other           reads 0, writes ignored, still acked
//
// Ports:
//   clk_i, reset_n_i        clock, synchronous active-low reset
//   cyc_i/stb_i/we_i        Wishbone cycle, strobe, write enable
//   adr_i, dat_i, sel_i     byte address, write data, byte lane selects
//   cti_i, bte_i            cycle type / burst type (bte_i ignored)
//   ack_o/err_o/rty_o       terminations (rty_o tied low)
//   dat_o                   registered read data, valid with ack_o
//   spi_dat_o / spi_dat_i   TX word to / RX word from the engine
//   spi_start_o             one-cycle start pulse
//   spi_done_i              one-cycle transfer-complete pulse
//   spi_sel_o               chip-select index
//   irq_o                   level interrupt = IRQ_EN & (DONE | OVR)
// -----------------------------------------------------------------------------
module wb_spi_ctrl_regs #(
    parameter int SPI_DW   = 32,
    parameter int NUM_CS   = 4,
    parameter int ADR_BITS = 10,
    localparam int CSW     = $clog2(NUM_CS)
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              cyc_i,
    input  logic              stb_i,
    input  logic              we_i,
    input  logic [31:0]       adr_i,
    input  logic [31:0]       dat_i,
    input  logic [3:0]        sel_i,
    input  logic [2:0]        cti_i,
    input  logic [1:0]        bte_i,
    output logic              ack_o,
    output logic              err_o,
    output logic              rty_o,
    output logic [31:0]       dat_o,
    output logic [SPI_DW-1:0] spi_dat_o,
    input  logic [SPI_DW-1:0] spi_dat_i,
    output logic              spi_start_o,
    input  logic              spi_done_i,
    output logic [CSW-1:0]    spi_sel_o,
    output logic              irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SINGLE,
        ST_BURST,
        ST_ERR
    } bus_state_t;

    localparam logic [ADR_BITS-1:0] A_TXDATA = ADR_BITS'(0);
    localparam logic [ADR_BITS-1:0] A_RXDATA = ADR_BITS'(1);
    localparam logic [ADR_BITS-1:0] A_CTRL   = ADR_BITS'(2);
    localparam logic [ADR_BITS-1:0] A_STATUS = ADR_BITS'(3);

    bus_state_t          state_q, state_d;
    logic                accept;
    logic                ack_q;
    logic [SPI_DW-1:0]   tx_q;
    logic [SPI_DW-1:0]   rx_q;
    logic                irq_en_q;
    logic [CSW-1:0]      cs_q;
    logic                busy_q, done_q, ovr_q;

    logic [ADR_BITS-1:0] word_adr;
    logic                cti_classic, cti_incr, cti_end;
    logic                wr_tx, wr_ctrl, wr_status;
    logic                start_wr, start_ok, ovr_set, done_clr, ovr_clr;
    logic [31:0]         lane_mask, tx_merged, rd_data;

    // Address bits outside the decoded word field and the burst type are
    // deliberately not used.
    logic unused_bits;
    assign unused_bits = ^{bte_i, adr_i[31:ADR_BITS+2], adr_i[1:0]};

    assign word_adr    = adr_i[ADR_BITS+1:2];
    assign cti_end     = (cti_i == 3'b111);
    assign cti_classic = (cti_i == 3'b000) | cti_end;
    assign cti_incr    = (cti_i == 3'b001) | (cti_i == 3'b010);

    // ---------------------------------------------------------------- bus FSM
    // State register.
    // NOTE: reset is sampled on the clock edge only; it is not in the
    // sensitivity list, so it cannot act between edges.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    // Next state; 'accept' marks a beat that is acked and commits.
    // NOTE: every variable written here gets a default first so no latch
    // is inferred on paths that do not assign it.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cyc_i && stb_i) begin
                    if (cti_classic) begin
                        state_d = ST_SINGLE;
                        accept  = 1'b1;
                    end else if (cti_incr) begin
                        state_d = ST_BURST;
                        accept  = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            // Forced idle cycle: a classic master still holds stb_i while
            // it sees ack_o, so it must not be taken as a second request.
            ST_SINGLE: state_d = ST_IDLE;
            ST_BURST: begin
                if (!cyc_i) begin
                    state_d = ST_IDLE;
                end else if (stb_i) begin
                    if (cti_incr) begin
                        accept = 1'b1;
                    end else if (cti_end) begin
                        state_d = ST_IDLE;
                        accept  = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        ack_o = ack_q;
        err_o = (state_q == ST_ERR);
    end

    assign rty_o = 1'b0;

    // ------------------------------------------------------------ read path
    always_comb begin
        rd_data = '0;
        unique case (word_adr)
            A_TXDATA: rd_data = 32'(tx_q);
            A_RXDATA: rd_data = 32'(rx_q);
            A_CTRL: begin
                rd_data[1]        = irq_en_q;
                rd_data[8 +: CSW] = cs_q;
            end
            A_STATUS: rd_data[2:0] = {ovr_q, done_q, busy_q};
            default:  rd_data = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            ack_q <= 1'b0;
            dat_o <= '0;
        end else begin
            ack_q <= accept;
            dat_o <= (accept && !we_i) ? rd_data : 32'h0;
        end
    end

    // ----------------------------------------------------------- write path
    assign wr_tx     = accept & we_i & (word_adr == A_TXDATA);
    assign wr_ctrl   = accept & we_i & (word_adr == A_CTRL);
    assign wr_status = accept & we_i & (word_adr == A_STATUS);

    assign lane_mask = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
    assign tx_merged = (dat_i & lane_mask) | (32'(tx_q) & ~lane_mask);

    // A completion in the same cycle frees the engine, so a start that
    // coincides with spi_done_i is accepted rather than flagged as overrun.
    assign start_wr = wr_ctrl & sel_i[0] & dat_i[0];
    assign start_ok = start_wr & (~busy_q | spi_done_i);
    assign ovr_set  = start_wr & busy_q & ~spi_done_i;
    assign done_clr = wr_status & sel_i[0] & dat_i[1];
    assign ovr_clr  = wr_status & sel_i[0] & dat_i[2];

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            tx_q        <= '0;
            rx_q        <= '0;
            irq_en_q    <= 1'b0;
            cs_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovr_q       <= 1'b0;
            spi_start_o <= 1'b0;
        end else begin
            if (wr_tx) tx_q <= tx_merged[SPI_DW-1:0];
            if (spi_done_i) rx_q <= spi_dat_i;

            if (wr_ctrl && sel_i[0]) irq_en_q <= dat_i[1];
            if (wr_ctrl && sel_i[1]) cs_q     <= dat_i[8 +: CSW];

            if (start_ok)        busy_q <= 1'b1;
            else if (spi_done_i) busy_q <= 1'b0;

            // Set beats clear for both sticky flags.
            if (spi_done_i)    done_q <= 1'b1;
            else if (done_clr) done_q <= 1'b0;

            if (ovr_set)      ovr_q <= 1'b1;
            else if (ovr_clr) ovr_q <= 1'b0;

            spi_start_o <= start_ok;
        end
    end

    assign spi_dat_o = tx_q;
    assign spi_sel_o = cs_q;
    assign irq_o     = irq_en_q & (done_q | ovr_q);

endmodule

// File: tb/tb_wb_spi_ctrl_regs.sv
// -----------------------------------------------------------------------------
// tb_wb_spi_ctrl_regs
//
// Directed testbench for wb_spi_ctrl_regs (default parameters: SPI_DW=32,
// NUM_CS=4, ADR_BITS=10). Inputs are driven on the falling edge and outputs
// are sampled on the falling edge, half a cycle after the active edge.
// -----------------------------------------------------------------------------
module tb_wb_spi_ctrl_regs;

    localparam int SPI_DW = 32;
    localparam int NUM_CS = 4;
    localparam int CSW    = $clog2(NUM_CS);

    logic              clk_i = 1'b0;
    logic              reset_n_i;
    logic              cyc_i, stb_i, we_i;
    logic [31:0]       adr_i, dat_i;
    logic [3:0]        sel_i;
    logic [2:0]        cti_i;
    logic [1:0]        bte_i;
    logic              ack_o, err_o, rty_o;
    logic [31:0]       dat_o;
    logic [SPI_DW-1:0] spi_dat_o, spi_dat_i;
    logic              spi_start_o, spi_done_i;
    logic [CSW-1:0]    spi_sel_o;
    logic              irq_o;

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;

    wb_spi_ctrl_regs #(.SPI_DW(SPI_DW), .NUM_CS(NUM_CS), .ADR_BITS(10)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
        .adr_i(adr_i), .dat_i(dat_i), .sel_i(sel_i),
        .cti_i(cti_i), .bte_i(bte_i),
        .ack_o(ack_o), .err_o(err_o), .rty_o(rty_o), .dat_o(dat_o),
        .spi_dat_o(spi_dat_o), .spi_dat_i(spi_dat_i),
        .spi_start_o(spi_start_o), .spi_done_i(spi_done_i),
        .spi_sel_o(spi_sel_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Counts start pulse cycles so pulse width/multiplicity can be checked.
    always @(negedge clk_i) if (spi_start_o === 1'b1) pulses++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // One access: request held for one edge, then released plus one idle
    // cycle. Optionally a spi_done_i pulse accompanies the request edge.
    task automatic wb_cycle(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                            input logic [3:0] sel, input logic [2:0] cti,
                            input logic with_done, input logic [31:0] rx,
                            output logic ack, output logic err, output logic [31:0] rdat,
                            output logic start);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel; cti_i = cti;
        if (with_done) begin spi_done_i = 1'b1; spi_dat_i = rx; end
        @(negedge clk_i);
        ack = ack_o; err = err_o; rdat = dat_o; start = spi_start_o;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; cti_i = 3'b000; spi_done_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                            output logic start);
        logic a, e; logic [31:0] r;
        wb_cycle(adr, 1'b1, dat, sel, 3'b000, 1'b0, 32'h0, a, e, r, start);
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic ack, output logic [31:0] rdat);
        logic e, s;
        wb_cycle(adr, 1'b0, 32'h0, 4'hF, 3'b000, 1'b0, 32'h0, ack, e, rdat, s);
    endtask

    task automatic spi_done_pulse(input logic [31:0] rx);
        spi_done_i = 1'b1; spi_dat_i = rx;
        @(negedge clk_i);
        spi_done_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        logic a; logic [31:0] r;
        reset_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
        vectors++;
        if ({ack_o, err_o, rty_o, spi_start_o, irq_o} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: ack/err/rty/start/irq = %b, expected 00000",
                     {ack_o, err_o, rty_o, spi_start_o, irq_o});
        end
        vectors++;
        if (dat_o !== 32'h0 || spi_dat_o !== 32'h0 || spi_sel_o !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_data: dat_o=%h spi_dat_o=%h sel=%0d, expected 0", dat_o, spi_dat_o, spi_sel_o);
        end
        reset_n_i = 1'b1;
        @(negedge clk_i);
        for (int w = 0; w < 4; w++) begin
            wb_read(32'(w * 4), a, r);
            vectors++;
            if (a !== 1'b1 || r !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_read_w%0d: ack=%b dat=%h, expected ack=1 dat=00000000", w, a, r);
            end
        end
        begin
            logic e, s;
            wb_cycle(32'h0000_0FFC, 1'b0, 32'h0, 4'hF, 3'b000, 1'b0, 32'h0, a, e, r, s);
            vectors++;
            if (a !== 1'b1 || e !== 1'b0 || r !== 32'h0) begin
                miscompares++;
                $display("FAIL unmapped_read: ack=%b err=%b dat=%h, expected 1 0 00000000", a, e, r);
            end
        end
    endtask

    task automatic test_byte_lanes();
        logic a, s; logic [31:0] r;
        wb_write(32'h0, 32'h1122_3344, 4'b1111, s);
        wb_write(32'h0, 32'hAABB_CCDD, 4'b0101, s);
        wb_read(32'h0, a, r);
        vectors++;
        if (r !== 32'h11BB_33DD) begin
            miscompares++;
            $display("FAIL txdata_lanes: got %h, expected 11bb33dd", r);
        end
        vectors++;
        if (spi_dat_o !== 32'h11BB_33DD) begin
            miscompares++;
            $display("FAIL spi_dat_o: got %h, expected 11bb33dd", spi_dat_o);
        end
    endtask

    task automatic test_ctrl_start();
        logic a, s; logic [31:0] r; int p0;
        p0 = pulses;
        wb_write(32'h8, 32'h0000_0302, 4'b1111, s);
        vectors++;
        if (s !== 1'b0 || spi_sel_o !== 2'd3 || pulses != p0) begin
            miscompares++;
            $display("FAIL ctrl_302: start=%b sel=%0d pulses=%0d, expected 0 3 0", s, spi_sel_o, pulses - p0);
        end
        wb_write(32'h8, 32'h0000_0301, 4'b1111, s);
        vectors++;
        if (s !== 1'b1 || pulses != p0 + 1) begin
            miscompares++;
            $display("FAIL start_pulse: start_at_ack=%b pulses=%0d, expected 1 1", s, pulses - p0);
        end
        wb_read(32'h8, a, r);
        vectors++;
        if (r !== 32'h0000_0300) begin
            miscompares++;
            $display("FAIL ctrl_read: got %h, expected 00000300", r);
        end
        wb_read(32'hC, a, r);
        vectors++;
        if (r !== 32'h1 || irq_o !== 1'b0) begin
            miscompares++;
            $display("FAIL status_busy: status=%h irq=%b, expected 00000001 0", r, irq_o);
        end
        spi_done_pulse(32'h5A5A_5A5A);
        wb_read(32'hC, a, r);
        vectors++;
        if (r !== 32'h2 || irq_o !== 1'b0) begin
            miscompares++;
            $display("FAIL status_done: status=%h irq=%b, expected 00000002 0", r, irq_o);
        end
        wb_read(32'h4, a, r);
        vectors++;
        if (r !== 32'h5A5A_5A5A) begin
            miscompares++;
            $display("FAIL rxdata: got %h, expected 5a5a5a5a", r);
        end
    endtask

    task automatic test_overrun();
        logic a, s; logic [31:0] r; int p0;
        wb_write(32'hC, 32'h2, 4'b0001, s);
        p0 = pulses;
        wb_write(32'h8, 32'h0000_0303, 4'b0011, s);
        wb_read(32'hC, a, r);
        vectors++;
        if (r !== 32'h1 || irq_o !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_pre: status=%h irq=%b, expected 00000001 0", r, irq_o);
        end
        wb_write(32'h8, 32'h0000_0303, 4'b0011, s);
        vectors++;
        if (s !== 1'b0 || pulses != p0 + 1) begin
            miscompares++;
            $display("FAIL ovr_no_pulse: start=%b pulses=%0d, expected 0 1", s, pulses - p0);
        end
        wb_read(32'hC, a, r);
        vectors++;
        if (r !== 32'h5 || irq_o !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_status: status=%h irq=%b, expected 00000005 1", r, irq_o);
        end
        wb_write(32'hC, 32'h6, 4'b0001, s);
        wb_read(32'hC, a, r);
        vectors++;
        if (r !== 32'h1 || irq_o !== 1'b0) begin
            miscompares++;
            $display("FAIL w1c: status=%h irq=%b, expected 00000001 0", r, irq_o);
        end
        spi_done_pulse(32'h0F0F_0F0F);
        vectors++;
        if (irq_o !== 1'b1) begin
            miscompares++;
            $display("FAIL irq_done: irq=%b, expected 1", irq_o);
        end
    endtask

    task automatic test_burst();
        logic [31:0] exp_dat [3];
        logic [2:0]  cti_seq [3];
        logic a, e, s; logic [31:0] r;
        exp_dat[0] = 32'h11BB_33DD; exp_dat[1] = 32'h0F0F_0F0F; exp_dat[2] = 32'h0000_0302;
        cti_seq[0] = 3'b010;        cti_seq[1] = 3'b010;        cti_seq[2] = 3'b111;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; sel_i = 4'hF;
        for (int b = 0; b < 3; b++) begin
            adr_i = 32'(b * 4); cti_i = cti_seq[b];
            @(negedge clk_i);
            vectors++;
            if (ack_o !== 1'b1 || err_o !== 1'b0 || dat_o !== exp_dat[b]) begin
                miscompares++;
                $display("FAIL burst_beat%0d: ack=%b err=%b dat=%h, expected 1 0 %h", b, ack_o, err_o, dat_o, exp_dat[b]);
            end
        end
        cyc_i = 1'b0; stb_i = 1'b0; cti_i = 3'b000;
        @(negedge clk_i);
        vectors++;
        if (ack_o !== 1'b0) begin
            miscompares++;
            $display("FAIL burst_end: ack=%b, expected 0", ack_o);
        end
        wb_cycle(32'h0, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b011, 1'b0, 32'h0, a, e, r, s);
        vectors++;
        if (e !== 1'b1 || a !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_cti: err=%b ack=%b, expected 1 0", e, a);
        end
        wb_read(32'h0, a, r);
        vectors++;
        if (r !== 32'h11BB_33DD || err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_cti_nowrite: txdata=%h err=%b, expected 11bb33dd 0", r, err_o);
        end
    endtask

    task automatic test_simultaneous();
        logic a, e, s; logic [31:0] r; int p0;
        p0 = pulses;
        wb_write(32'h8, 32'h0000_0303, 4'b0011, s);
        wb_write(32'hC, 32'h2, 4'b0001, s);
        wb_cycle(32'h8, 1'b1, 32'h0000_0303, 4'b0011, 3'b000, 1'b1, 32'h1234_5678, a, e, r, s);
        vectors++;
        if (s !== 1'b1 || pulses != p0 + 2) begin
            miscompares++;
            $display("FAIL done_and_start: start=%b pulses=%0d, expected 1 2", s, pulses - p0);
        end
        wb_read(32'hC, a, r);
        vectors++;
        if (r !== 32'h3) begin
            miscompares++;
            $display("FAIL done_and_start_status: got %h, expected 00000003", r);
        end
        wb_cycle(32'hC, 1'b1, 32'h2, 4'b0001, 3'b000, 1'b1, 32'h9ABC_DEF0, a, e, r, s);
        wb_read(32'hC, a, r);
        vectors++;
        if (r !== 32'h2) begin
            miscompares++;
            $display("FAIL done_beats_w1c: got %h, expected 00000002", r);
        end
        wb_cycle(32'h4, 1'b0, 32'h0, 4'hF, 3'b000, 1'b1, 32'hCAFE_F00D, a, e, r, s);
        vectors++;
        if (r !== 32'h9ABC_DEF0) begin
            miscompares++;
            $display("FAIL rx_read_old: got %h, expected 9abcdef0", r);
        end
        wb_read(32'h4, a, r);
        vectors++;
        if (r !== 32'hCAFE_F00D) begin
            miscompares++;
            $display("FAIL rx_read_new: got %h, expected cafef00d", r);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic a; logic [31:0] r;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; sel_i = 4'hF; adr_i = 32'h0; cti_i = 3'b010;
        @(negedge clk_i);
        vectors++;
        if (ack_o !== 1'b1 || irq_o !== 1'b1 || spi_sel_o !== 2'd3) begin
            miscompares++;
            $display("FAIL pre_reset: ack=%b irq=%b sel=%0d, expected 1 1 3", ack_o, irq_o, spi_sel_o);
        end
        adr_i = 32'h4;
        reset_n_i = 1'b0;
        @(negedge clk_i);
        vectors++;
        if ({ack_o, err_o, spi_start_o, irq_o} !== 4'b0 || dat_o !== 32'h0 ||
            spi_sel_o !== 2'd0 || spi_dat_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_burst: ack=%b err=%b start=%b irq=%b dat=%h sel=%0d spi_dat=%h, expected all 0",
                     ack_o, err_o, spi_start_o, irq_o, dat_o, spi_sel_o, spi_dat_o);
        end
        cyc_i = 1'b0; stb_i = 1'b0; cti_i = 3'b000;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        wb_read(32'hC, a, r);
        vectors++;
        if (a !== 1'b1 || r !== 32'h0) begin
            miscompares++;
            $display("FAIL post_reset_status: ack=%b status=%h, expected 1 00000000", a, r);
        end
    endtask

    initial begin
        reset_n_i  = 1'b0;
        cyc_i      = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        adr_i      = '0;   dat_i = '0;   sel_i = '0;
        cti_i      = '0;   bte_i = '0;
        spi_dat_i  = '0;   spi_done_i = 1'b0;
        @(negedge clk_i);
        test_reset();
        test_byte_lanes();
        test_ctrl_start();
        test_overrun();
        test_burst();
        test_simultaneous();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
